// File: rtl/pll_reset_ce_gen.sv
// pll_reset_ce_gen: reset sequencer and clock-enable generator behind the system PLL.
//
// Qualifies the asynchronous PLL lock, holds the core in reset for a fixed time after
// qualification or after a soft-reset request, and produces divided clock enables
// while the core runs. Also counts lock losses that occur while the core is running.
//
// Ports
//   clk_sys        in   24 MHz PLL output clock, rising edge
//   rst_n          in   asynchronous active-low reset, clears all state
//   pll_locked     in   PLL lock, asynchronous to clk_sys
//   rst_req        in   soft reset request level, asynchronous
//   core_rst_n     out  qualified core reset, active-low, high only in RUN
//   ce_a           out  one-cycle enable every CE_DIV_A cycles in RUN
//   ce_b           out  one-cycle enable every CE_DIV_B cycles in RUN
//   seq_state      out  sequencer state: 00 WAIT_LOCK, 01 STABLE, 10 HOLD, 11 RUN
//   lock_loss_cnt  out  saturating count of lock losses seen in RUN

module pll_reset_ce_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RST_HOLD    = 16,
  parameter int unsigned CE_DIV_A    = 4,
  parameter int unsigned CE_DIV_B    = 10
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       rst_req,
  output logic       core_rst_n,
  output logic       ce_a,
  output logic       ce_b,
  output logic [1:0] seq_state,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned StabW = $clog2(LOCK_STABLE);
  localparam int unsigned HoldW = $clog2(RST_HOLD);
  localparam int unsigned DivAW = $clog2(CE_DIV_A);
  localparam int unsigned DivBW = $clog2(CE_DIV_B);

  localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);
  localparam logic [DivAW-1:0] DivALast = DivAW'(CE_DIV_A - 1);
  localparam logic [DivBW-1:0] DivBLast = DivBW'(CE_DIV_B - 1);

  typedef enum logic [1:0] {
    StWaitLock = 2'b00,
    StStable   = 2'b01,
    StHold     = 2'b10,
    StRun      = 2'b11
  } seq_state_e;

  seq_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, req_sync_q;
  logic [StabW-1:0]       stab_q, stab_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [DivAW-1:0]       div_a_q, div_a_d;
  logic [DivBW-1:0]       div_b_q, div_b_d;
  logic [7:0]             loss_q, loss_d;
  logic                   core_rst_n_q;
  logic                   ce_a_q, ce_a_d;
  logic                   ce_b_q, ce_b_d;
  logic                   lock_s, req_s;
  logic                   run_stay;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign req_s  = req_sync_q[SYNC_STAGES-1];

  // Sequencer next state. A lock drop is checked first in every state so it always
  // restarts qualification and wins over a simultaneous soft-reset request.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    loss_d  = loss_q;
    case (state_q)
      StWaitLock: begin
        stab_d = '0;
        if (lock_s) state_d = StStable;
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          stab_d  = '0;
        end else if (stab_q == StabLast) begin
          state_d = StHold;
          stab_d  = '0;
          hold_d  = '0;
        end else begin
          stab_d = stab_q + StabW'(1);
        end
      end
      StHold: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          hold_d  = '0;
        end else if (req_s) begin
          // Hold time is measured from the release of the request.
          hold_d = '0;
        end else if (hold_q == HoldLast) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end else if (req_s) begin
          state_d = StHold;
          hold_d  = '0;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Dividers only advance while RUN persists across the edge, so they start from 0 on
  // entry and the enables are forced low on the edge that leaves RUN.
  assign run_stay = (state_q == StRun) && (state_d == StRun);

  always_comb begin
    div_a_d = '0;
    div_b_d = '0;
    ce_a_d  = 1'b0;
    ce_b_d  = 1'b0;
    if (run_stay) begin
      ce_a_d  = (div_a_q == DivALast);
      ce_b_d  = (div_b_q == DivBLast);
      div_a_d = ce_a_d ? '0 : div_a_q + DivAW'(1);
      div_b_d = ce_b_d ? '0 : div_b_q + DivBW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q  <= '0;
      req_sync_q   <= '0;
      state_q      <= StWaitLock;
      stab_q       <= '0;
      hold_q       <= '0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      loss_q       <= '0;
      core_rst_n_q <= 1'b0;
      ce_a_q       <= 1'b0;
      ce_b_q       <= 1'b0;
    end else begin
      lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
      req_sync_q   <= {req_sync_q[SYNC_STAGES-2:0], rst_req};
      state_q      <= state_d;
      stab_q       <= stab_d;
      hold_q       <= hold_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      loss_q       <= loss_d;
      core_rst_n_q <= (state_d == StRun);
      ce_a_q       <= ce_a_d;
      ce_b_q       <= ce_b_d;
    end
  end

  assign core_rst_n    = core_rst_n_q;
  assign ce_a          = ce_a_q;
  assign ce_b          = ce_b_q;
  assign seq_state     = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// tb_pll_reset_ce_gen: directed and randomized checks of pll_reset_ce_gen against a
// timestamp-based reference model (phase + entry time, enables from elapsed time).

module tb_pll_reset_ce_gen;

  localparam int SYNC = 2;
  localparam int LS   = 8;
  localparam int RH   = 4;
  localparam int DA   = 4;
  localparam int DB   = 10;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       rst_req = 1'b0;
  logic       core_rst_n, ce_a, ce_b;
  logic [1:0] seq_state;
  logic [7:0] lock_loss_cnt;

  always #5 clk_sys = ~clk_sys;

  pll_reset_ce_gen #(
    .SYNC_STAGES(SYNC),
    .LOCK_STABLE(LS),
    .RST_HOLD   (RH),
    .CE_DIV_A   (DA),
    .CE_DIV_B   (DB)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .rst_req      (rst_req),
    .core_rst_n   (core_rst_n),
    .ce_a         (ce_a),
    .ce_b         (ce_b),
    .seq_state    (seq_state),
    .lock_loss_cnt(lock_loss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs pass through a SYNC-deep delay queue; the sequencer is a
  // phase (0 wait, 1 stable, 2 hold, 3 run) plus the cycle at which its timer started.
  bit lq[$];
  bit rqq[$];
  int cyc = 0;
  int m_mode = 0;
  int m_t = 0;
  int m_loss = 0;

  function automatic void model_reset();
    lq = {};
    rqq = {};
    for (int i = 0; i < SYNC; i++) begin
      lq.push_back(1'b0);
      rqq.push_back(1'b0);
    end
    m_mode = 0;
    m_t    = 0;
    m_loss = 0;
  endfunction

  function automatic void model_step(input bit pl, input bit rq);
    bit ls, rs;
    ls = lq.pop_front();
    rs = rqq.pop_front();
    lq.push_back(pl);
    rqq.push_back(rq);
    cyc++;
    case (m_mode)
      0: if (ls) begin m_mode = 1; m_t = cyc; end
      1: begin
        if (!ls) m_mode = 0;
        else if (cyc - m_t == LS) begin m_mode = 2; m_t = cyc; end
      end
      2: begin
        if (!ls) m_mode = 0;
        else if (rs) m_t = cyc;
        else if (cyc - m_t == RH) begin m_mode = 3; m_t = cyc; end
      end
      default: begin
        if (!ls) begin
          m_mode = 0;
          if (m_loss < 255) m_loss++;
        end else if (rs) begin
          m_mode = 2;
          m_t = cyc;
        end
      end
    endcase
  endfunction

  function automatic bit exp_ce(input int div);
    return (m_mode == 3) && (cyc != m_t) && (((cyc - m_t) % div) == 0);
  endfunction

  task automatic compare_all();
    check_eq("seq_state", seq_state, m_mode);
    check_eq("core_rst_n", core_rst_n, (m_mode == 3));
    check_eq("ce_a", ce_a, exp_ce(DA));
    check_eq("ce_b", ce_b, exp_ce(DB));
    check_eq("lock_loss_cnt", lock_loss_cnt, m_loss);
  endtask

  // Drive on the falling edge, update the model at the rising edge, sample 1 ns later.
  task automatic tick(input bit pl, input bit rq);
    @(negedge clk_sys);
    pll_locked = pl;
    rst_req    = rq;
    @(posedge clk_sys);
    if (rst_n) model_step(pl, rq);
    #1;
    compare_all();
  endtask

  // Asserts rst_n between clock edges and checks outputs before any edge arrives.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check_eq("async_core_rst_n", core_rst_n, 0);
    check_eq("async_loss", lock_loss_cnt, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    @(posedge clk_sys);
    model_step(pll_locked, rst_req);
    #1;
    compare_all();
  endtask

  task automatic bring_up(output int edges);
    edges = 0;
    while (!core_rst_n && edges < 40) begin
      tick(1'b1, 1'b0);
      edges++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rst, first_cea, n_cea, seq_at, up, fall, rise, loss0;
    bit pl_r, rq_r;

    async_reset();
    repeat (3) tick(1'b0, 1'b0);

    // Lock rise right after edge 0: release at edge 15, first ce_a at 19, then every 4.
    first_rst = -1;
    first_cea = -1;
    n_cea     = 0;
    for (int n = 1; n <= 25; n++) begin
      tick(1'b1, 1'b0);
      if (core_rst_n && first_rst < 0) first_rst = n;
      if (ce_a && first_cea < 0) first_cea = n;
      if (ce_a) n_cea++;
    end
    check_eq("latency_core_rst", first_rst, 15);
    check_eq("first_ce_a", first_cea, 19);
    check_eq("ce_a_count", n_cea, 2);

    // Lock loss in RUN: core reset asserted 3 edges after the drop.
    fall = 0;
    while (core_rst_n && fall < 8) begin
      tick(1'b0, 1'b0);
      fall++;
    end
    check_eq("loss_fall_edges", fall, 3);
    check_eq("loss_count_first", lock_loss_cnt, 1);
    repeat (3) tick(1'b0, 1'b0);

    // One-cycle drop while STABLE with stab_cnt=5: full requalification.
    first_rst = -1;
    seq_at    = -1;
    for (int n = 1; n <= 30; n++) begin
      tick((n != 9), 1'b0);
      if (n == 11) seq_at = seq_state;
      if (core_rst_n && first_rst < 0) first_rst = n;
    end
    check_eq("glitch_seq_wait", seq_at, 0);
    check_eq("glitch_requal_rise", first_rst, 24);

    // 299 more losses: counter saturates.
    for (int k = 0; k < 299; k++) begin
      bring_up(up);
      check_eq("bring_up", core_rst_n, 1);
      repeat (3) tick(1'b0, 1'b0);
    end
    check_eq("loss_saturated", lock_loss_cnt, 255);

    // Async reset mid-RUN.
    bring_up(up);
    check_eq("run_before_reset", seq_state, 3);
    async_reset();

    // Soft reset pulse of 6 cycles in RUN.
    bring_up(up);
    loss0 = lock_loss_cnt;
    fall  = -1;
    rise  = -1;
    for (int n = 1; n <= 20; n++) begin
      tick(1'b1, (n <= 6));
      if (!core_rst_n && fall < 0) fall = n;
      if (core_rst_n && fall >= 0 && rise < 0) rise = n;
    end
    check_eq("req_fall_edge", fall, 3);
    check_eq("req_rise_edge", rise, 12);
    check_eq("req_loss_unchanged", lock_loss_cnt, loss0);

    // Request and lock loss together: lock loss wins.
    repeat (3) tick(1'b0, 1'b1);
    check_eq("both_seq_wait", seq_state, 0);
    check_eq("both_loss_inc", lock_loss_cnt, loss0 + 1);
    tick(1'b0, 1'b0);

    // Async reset mid-HOLD.
    bring_up(up);
    repeat (4) tick(1'b1, 1'b1);
    check_eq("hold_before_reset", seq_state, 2);
    async_reset();

    // Randomized lock and request activity with occasional async resets.
    pl_r = 1'b1;
    rq_r = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) pl_r = !pl_r;
      if (!rq_r && $urandom_range(0, 79) == 0) rq_r = 1'b1;
      else if (rq_r && $urandom_range(0, 3) == 0) rq_r = 1'b0;
      if ($urandom_range(0, 399) == 0) async_reset();
      else tick(pl_r, rq_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
